// File: rtl/egress_scheduler.sv
// -----------------------------------------------------------------------------
// egress_scheduler
//
// Read side of the per-port packet queues in the 4x4 switch. There is one
// instance per output port. The scheduler watches the four input-port queues
// that target this output, pops them in round-robin order and holds each grant
// for up to MAX_BURST consecutive words. Popped words leave on a registered
// valid/ready stream tagged with the index of the source input.
//
// Parameters
//   DATA_W     payload width; each queue word is DATA_W+1 bits, MSB = non-empty
//   MAX_BURST  maximum consecutive pops per grant (1..15)
//
// Ports
//   clk                   clock, rising edge
//   rst                   asynchronous active-low reset
//   q_data0..q_data3      queue head words (bit DATA_W = queue non-empty)
//   q_rd_en               one-hot pop strobes, forced to 0 while rst=0
//   out_data / out_src    registered payload and its source input index
//   out_valid / out_ready output stream handshake
//
// Optional build feature (define EGRESS_SCHED_STATS_EN)
//   stat_sel   selects one of four saturating 16-bit per-input pop counters
//   stat_count combinational read of the selected counter
// -----------------------------------------------------------------------------
module egress_scheduler #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W:0]   q_data0,
  input  logic [DATA_W:0]   q_data1,
  input  logic [DATA_W:0]   q_data2,
  input  logic [DATA_W:0]   q_data3,
  output logic [3:0]        q_rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_valid,
  input  logic              out_ready
`ifdef EGRESS_SCHED_STATS_EN
  ,
  input  logic [1:0]        stat_sel,
  output logic [15:0]       stat_count
`endif
);

  localparam logic [3:0] MaxBurst   = MAX_BURST[3:0];
  // With a burst length of 1 the grant is released right after the pop and
  // the BURST state is never entered.
  localparam bit         SingleWord = (MAX_BURST <= 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0]   out_data_q;
  logic [1:0]          out_src_q;
  logic                out_valid_q;

  logic [DATA_W:0]     q_head [4];
  logic [3:0]          ne;
  logic                can_load;
  logic                win_found;
  logic [1:0]          win_idx;
  logic [1:0]          cand;
  logic                pop;
  logic [1:0]          pop_idx;
  logic [3:0]          rd_en_raw;

  assign q_head[0] = q_data0;
  assign q_head[1] = q_data1;
  assign q_head[2] = q_data2;
  assign q_head[3] = q_data3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ne[i] = q_head[i][DATA_W];
    end
  end

  assign can_load = !out_valid_q || out_ready;

  // Round-robin search starting at rr_ptr. Scanning from the farthest offset
  // down lets the nearest non-empty queue overwrite the result last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (ne[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and pop decision
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    burst_cnt_d = burst_cnt_q;
    pop         = 1'b0;
    pop_idx     = gnt_q;

    unique case (state_q)
      StIdle: begin
        if (win_found && can_load) begin
          pop         = 1'b1;
          pop_idx     = win_idx;
          gnt_d       = win_idx;
          burst_cnt_d = 4'd1;
          if (SingleWord) begin
            rr_ptr_d = win_idx + 2'd1;
          end else begin
            state_d = StBurst;
          end
        end
      end
      StBurst: begin
        if (ne[gnt_q] && (burst_cnt_q < MaxBurst)) begin
          // A stall holds everything, so backpressure never eats burst budget.
          if (can_load) begin
            pop         = 1'b1;
            pop_idx     = gnt_q;
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else begin
          rr_ptr_d    = gnt_q + 2'd1;
          burst_cnt_d = 4'd0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rd_en_raw = pop ? (4'b0001 << pop_idx) : 4'b0000;
  // State is already cleared by the async reset, but the winner search is
  // purely combinational, so the strobes must be gated explicitly.
  assign q_rd_en   = rst ? rd_en_raw : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 2'd0;
      gnt_q       <= 2'd0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Output register: a load always wins, which also covers load-and-accept
  // in the same cycle without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'd0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= q_head[pop_idx][DATA_W-1:0];
      out_src_q   <= pop_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

`ifdef EGRESS_SCHED_STATS_EN
  logic [15:0] stat_q [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        stat_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pop && (pop_idx == 2'(i)) && (stat_q[i] != 16'hFFFF)) begin
          stat_q[i] <= stat_q[i] + 16'd1;
        end
      end
    end
  end

  assign stat_count = stat_q[stat_sel];
`endif

endmodule

// File: doc/egress_scheduler.md
Name: egress_scheduler

Overview:
- Read side of the per-port packet queues in the 4x4 switch; one instance per output port.
- Watches the four input-port queues that target this output and pops them in round-robin order, holding a grant for up to MAX_BURST consecutive words.
- Drives a registered valid/ready stream towards the output port, tagged with the source input number.

Parameters:
- DATA_W, 32, payload width; each queue word is DATA_W+1 bits, with bit DATA_W as the valid flag.
- MAX_BURST, 4, maximum consecutive words popped from one queue per grant; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low: 0 clears all state immediately; deassertion is synchronised externally.
- q_data0..q_data3  in  DATA_W+1 each  queue head word; bit DATA_W=1 means the queue is non-empty; an empty queue presents all zeros.
- q_rd_en  out  4  one-hot pop strobes; the queue advances on the rising edge where its bit is 1.
- out_data  out  DATA_W  registered payload.
- out_src  out  2  input-port index of out_data.
- out_valid  out  1  out_data/out_src are valid.
- out_ready  in  1  downstream accepts the word on a rising edge where out_valid=1.

Behaviour:
- Reset (rst=0):
  - out_valid=0, out_data=0, out_src=0.
  - q_rd_en=0, held combinationally to 0 while rst=0.
  - rr_ptr=0, state=IDLE, gnt=0, burst_cnt=0.
  - Reset mid-burst drops the burst. A word already popped but not yet accepted is lost.
- Definitions:
  - can_load = !out_valid || out_ready.
  - ne[i] = q_dataN[DATA_W].
- State IDLE:
  - winner = first i with ne[i]=1, searching rr_ptr, rr_ptr+1, ... mod 4.
  - If a winner exists and can_load: q_rd_en[winner]=1 this cycle. Next edge: out_data<=q_data[winner][DATA_W-1:0], out_src<=winner, out_valid<=1, gnt<=winner, burst_cnt<=1.
  - Next state: BURST if MAX_BURST>1; otherwise stay IDLE with rr_ptr<=winner+1.
  - If no winner, or !can_load: no pop, stay IDLE.
- State BURST (grant held on gnt):
  - If ne[gnt] && burst_cnt<MAX_BURST && can_load: pop gnt, load the output as above, burst_cnt++.
  - If ne[gnt] && burst_cnt<MAX_BURST && !can_load: no pop, hold all state (stall does not consume burst budget).
  - Else (queue empty or burst_cnt==MAX_BURST): no pop, rr_ptr<=gnt+1 (mod 4), burst_cnt<=0, go IDLE. This costs one bubble cycle.
- Output register:
  - When out_valid && out_ready and no new load: out_valid<=0; out_data/out_src hold their values.
  - Load and accept in the same cycle: the new word replaces the old one with no bubble.
- Latency: a queue head visible in cycle N appears on out_valid at N+1.
  - Sustained throughput is 1 word/cycle within a burst.
  - Each grant change costs one idle cycle.
- Invariants:
  - q_rd_en is at most one-hot.
  - q_rd_en is never asserted for a queue with ne=0.
  - q_rd_en is never asserted when !can_load.
- Fairness: a continuously non-empty queue is served within 3*(MAX_BURST+1) cycles of out_ready held high.
- rr_ptr and gnt are 2-bit and wrap 3->0 naturally.
- burst_cnt is 4-bit.

Optional Feature:
- Macro: EGRESS_SCHED_STATS_EN.
- With the macro defined:
  - Extra ports stat_sel in 2, stat_count out 16.
  - Four 16-bit counters, one per input, each increment on every pop from that input and saturate at 16'hFFFF.
  - stat_count = counter[stat_sel], combinational.
  - Counters are cleared by rst.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset state: rst=0 with all queues non-empty -> q_rd_en=0, out_valid=0, out_data=0. After release with out_ready=1, the first pop is q_rd_en=4'b0001.
- Single source: only q_data2 non-empty with 3 words A,B,C, out_ready=1 -> q_rd_en=4'b0100 for 3 consecutive cycles, out_data A,B,C back-to-back with out_src=2, then one bubble, state IDLE, rr_ptr=3.
- Round-robin with MAX_BURST=4, all four queues holding 10 words each, out_ready=1 -> sources 0,0,0,0,(bubble),1,1,1,1,(bubble),2..., then 3, then back to 0.
- Backpressure: out_ready=0 for 5 cycles mid-burst -> q_rd_en=0 throughout and out_data stable; burst_cnt unchanged; no word lost or duplicated after out_ready returns to 1.
- Empty queue: queue 1 empties after 2 words mid-burst -> no pop of queue 1 while q_data1[32]=0; grant passes to queue 2 after one bubble.
- Stats (with EGRESS_SCHED_STATS_EN): 70000 pops from queue 3 -> stat_sel=3 reads 16'hFFFF; the other counters read their exact pop counts.
